// File: rtl/alu_exec_mc.sv
// ---------------------------------------------------------------------------------------------
// alu_exec_mc
//
// Execute-stage ALU with a registered result. AND/OR/ADD/SUB/SLT finish in one cycle; MUL runs
// an iterative shift-add multiplier over WIDTH cycles. Valid/ready handshakes on both sides let
// the core stall fetch/decode while a multiply is in flight.
//
// Ports:
//   clk         rising-edge clock
//   rst_n       asynchronous active-low reset
//   in_valid    operands + ALUControl valid this cycle
//   in_ready    block can accept an op this cycle (combinational)
//   ALUControl  3-bit op code from the ALU decoder
//   SrcA, SrcB  operands (WIDTH bits)
//   out_valid   ALUResult/Zero hold a completed op
//   out_ready   consumer takes the result this cycle
//   ALUResult   registered result (WIDTH bits)
//   Zero        registered (ALUResult == 0), meaningful only while out_valid is high
//   stall       in_valid & ~in_ready, for the hazard / PC-enable logic
//
// Op codes: 000 AND, 001 OR, 010 ADD, 100 SUB, 110 SLT (signed), 101 MUL (low WIDTH bits),
//           011 and 111 alias ADD. All arithmetic wraps modulo 2^WIDTH.
// ---------------------------------------------------------------------------------------------
module alu_exec_mc #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       ALUControl,
    input  logic [WIDTH-1:0] SrcA,
    input  logic [WIDTH-1:0] SrcB,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] ALUResult,
    output logic             Zero,
    output logic             stall
);

    localparam int unsigned CntW = $clog2(WIDTH);
    localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

    localparam logic [2:0] OpAnd = 3'b000;
    localparam logic [2:0] OpOr  = 3'b001;
    localparam logic [2:0] OpSub = 3'b100;
    localparam logic [2:0] OpSlt = 3'b110;
    localparam logic [2:0] OpMul = 3'b101;

    typedef enum logic [0:0] {
        StIdle,
        StMul
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             zero_q, zero_d;
    logic             valid_q, valid_d;

    logic             accept;
    logic             is_mul;
    logic [WIDTH-1:0] alu_res;
    logic [WIDTH-1:0] acc_step;

    // -----------------------------------------------------------------------------------------
    // Handshake
    // -----------------------------------------------------------------------------------------
    // A new op may enter only in IDLE, and only if the output slot is empty or being drained
    // on this same edge (this is what gives back-to-back issue without a bubble).
    assign in_ready = (state_q == StIdle) & (~valid_q | out_ready);
    assign accept   = in_valid & in_ready;
    assign stall    = in_valid & ~in_ready;
    assign is_mul   = (ALUControl == OpMul);

    assign out_valid = valid_q;
    assign ALUResult = res_q;
    assign Zero      = zero_q;

    // -----------------------------------------------------------------------------------------
    // Single-cycle datapath
    // -----------------------------------------------------------------------------------------
    always_comb begin
        alu_res = '0;
        case (ALUControl)
            OpAnd:   alu_res = SrcA & SrcB;
            OpOr:    alu_res = SrcA | SrcB;
            OpSub:   alu_res = SrcA - SrcB;
            OpSlt:   alu_res = {{(WIDTH-1){1'b0}}, ($signed(SrcA) < $signed(SrcB))};
            // MUL never loads from here; it takes the iterative path below.
            OpMul:   alu_res = '0;
            // 010 ADD plus the unused 011/111 codes.
            default: alu_res = SrcA + SrcB;
        endcase
    end

    // One shift-add step: add the shifted multiplicand when the current multiplier LSB is set.
    assign acc_step = acc_q + (mplier_q[0] ? mcand_q : '0);

    // -----------------------------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        res_d    = res_q;
        zero_d   = zero_q;
        valid_d  = valid_q;

        // Consumption first; a result loaded below on the same edge overrides it.
        if (valid_q && out_ready) begin
            valid_d = 1'b0;
        end

        case (state_q)
            StIdle: begin
                if (accept) begin
                    if (is_mul) begin
                        mcand_d  = SrcA;
                        mplier_d = SrcB;
                        acc_d    = '0;
                        cnt_d    = '0;
                        state_d  = StMul;
                    end else begin
                        res_d   = alu_res;
                        zero_d  = (alu_res == '0);
                        valid_d = 1'b1;
                    end
                end
            end

            StMul: begin
                acc_d    = acc_step;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + 1'b1;
                // No early exit: always WIDTH iterations, so latency is data-independent.
                if (cnt_q == LastCnt) begin
                    res_d   = acc_step;
                    zero_d  = (acc_step == '0);
                    valid_d = 1'b1;
                    state_d = StIdle;
                end
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // -----------------------------------------------------------------------------------------
    // State registers
    // -----------------------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            res_q    <= '0;
            zero_q   <= 1'b0;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            res_q    <= res_d;
            zero_q   <= zero_d;
            valid_q  <= valid_d;
        end
    end

endmodule
